// File: rtl/dpram_stream_reader_pkg.sv
// Shared types and sizing for the RAM stream reader and its skid buffer.
package dpram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = 2;

endpackage

// File: rtl/dpram_stream_reader_rd_skid_fifo.sv
// Two-entry {last,data} skid buffer; zero-latency head, flush and reset empty it.
// The caller never pushes into a full buffer, so no overflow guard is needed here.
module rd_skid_fifo
  import dpram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/dpram_stream_reader.sv
// Walks LEN words from BASE_ADDR through a 1-cycle-latency RAM read port and
// streams them valid/ready with a last flag; first word valid 3 cycles after start.
module dpram_stream_reader
  import dpram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] issue_ptr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  pop;
  logic                  issue;
  logic                  kill;
  logic [2:0]            occupancy;

  assign pop  = m_valid & m_ready;
  assign kill = abort && (state != ST_IDLE);

  // Words already buffered plus the one still in the RAM pipe, less the one leaving now.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == ST_RUN) && (remaining != '0) && (occupancy < 3'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      issue_ptr     <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (remaining == ADDR_WIDTH'(1));
      if (kill) begin
        state         <= ST_IDLE;
        done          <= 1'b1;
        inflight      <= 1'b0;
        inflight_last <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (len == '0) begin
                done <= 1'b1;
              end else begin
                state     <= ST_RUN;
                issue_ptr <= base_addr;
                remaining <= len;
              end
            end
          end
          ST_RUN: begin
            if (issue) begin
              issue_ptr <= issue_ptr + ADDR_WIDTH'(1);
              remaining <= remaining - ADDR_WIDTH'(1);
              if (remaining == ADDR_WIDTH'(1)) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (pop && m_last) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  rd_skid_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (kill),
    .push     (inflight),
    .push_data({inflight_last, ram_dout}),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign ram_addr = issue_ptr;
  assign m_valid  = !fifo_empty;
  assign m_data   = fifo_head[DATA_WIDTH-1:0];
  assign m_last   = m_valid & fifo_head[DATA_WIDTH];
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader with a 1-cycle registered RAM model.
module tb_dpram_stream_reader;

  logic        clk = 1'b0;
  logic        rst, start, abort, m_ready;
  logic [12:0] base_addr, len, ram_addr;
  logic [31:0] ram_dout, m_data;
  logic        m_valid, m_last, busy, done;
  logic [31:0] mem [8192];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dpram_stream_reader #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .abort(abort), .ram_addr(ram_addr), .ram_dout(ram_dout), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );

  always @(posedge clk) ram_dout <= mem[ram_addr];

  function automatic logic [31:0] word(input logic [12:0] a);
    return {3'b101, a, 3'b011, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic start_xfer(input logic [12:0] b, input logic [12:0] l);
    start = 1'b1; base_addr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic collect(input logic [12:0] b, input int l, input int mode);
    int          idx = 0;
    int          cyc = 0;
    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    logic [12:0] a;
    while (idx < l && cyc < 300) begin
      case (mode)
        1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      @(negedge clk);
      if (stalled) chk("stall_hold", m_data, held);
      if (m_valid && m_ready) begin
        a = b + 13'(idx);
        chk("data", m_data, word(a));
        chk("last", m_last, (idx == l - 1));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = m_valid;
        held    = m_data;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b1;
    if (idx < l) begin
      chk("timeout", idx, l);
    end else begin
      @(negedge clk);
      chk("done_after_last", done, 1);
      chk("busy_after_last", busy, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = word(13'(i));
    rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    base_addr = '0; len = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", ram_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // base 0x010 len 4, cycle-exact timing
    start_xfer(13'h010, 13'd4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) chk("t1_addr", ram_addr, 32'h10);
      chk("t1_valid", m_valid, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("t1_data", m_data, word(13'h010 + 13'(c - 3)));
      chk("t1_last", m_last, (c == 6));
      chk("t1_done", done, (c == 7));
      chk("t1_busy", busy, (c < 7));
      @(posedge clk); #1;
    end

    start_xfer(13'h1FFE, 13'd4);
    collect(13'h1FFE, 4, 0);

    start_xfer(13'h0080, 13'd8);
    collect(13'h0080, 8, 1);
    start_xfer(13'h0200, 13'd8);
    collect(13'h0200, 8, 2);

    // zero length
    start_xfer(13'h0300, 13'd0);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_valid", m_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("len0_done_off", done, 0);
    chk("len0_valid2", m_valid, 0);
    @(posedge clk); #1;

    // start while busy is ignored
    start_xfer(13'h0300, 13'd3);
    start_xfer(13'h0400, 13'd5);
    collect(13'h0300, 3, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ign_busy", busy, 0);
      chk("ign_valid", m_valid, 0);
      @(posedge clk); #1;
    end

    // abort in IDLE has no effect
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_done", done, 0);
    @(posedge clk); #1;

    // abort on the 3rd word of a 16-word transfer
    start_xfer(13'h0040, 13'd16);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("ab_word3", m_data, word(13'h0042));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("ab_valid", m_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ab_valid2", m_valid, 0);
    chk("ab_done2", done, 0);
    @(posedge clk); #1;
    start_xfer(13'h0100, 13'd2);
    collect(13'h0100, 2, 0);

    // start beats abort when both arrive in IDLE
    abort = 1'b1;
    start_xfer(13'h0600, 13'd2);
    abort = 1'b0;
    collect(13'h0600, 2, 0);

    // reset mid-transfer
    start_xfer(13'h0500, 13'd8);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_valid", m_valid, 0);
    chk("mr_last", m_last, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_addr", ram_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_done2", done, 0);
    chk("mr_valid2", m_valid, 0);
    @(posedge clk); #1;
    start_xfer(13'h0700, 13'd3);
    collect(13'h0700, 3, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
